regbank_write_arbiter: RTL and testbench
========================================

Name: regbank_write_arbiter

Overview:
Round-robin write arbiter and sequencer for a shared bank of positive-edge D-flip-flop registers. Up to NREQ requesters compete for write access. The block grants one requester at a time, commits its address/data into the bank, and acknowledges it. Read access is a combinational port into the same bank; the block sits between requester agents and the storage flops.

Parameters:
NREQ, 4, number of requesters (2..8)
DATA_W, 8, width of each bank register
ADDR_W, 3, address width; bank depth = 2**ADDR_W

Ports:
CLK  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
req  input  NREQ  per-requester write request, level
addr  input  NREQ*ADDR_W  packed write addresses, requester i at [i*ADDR_W +: ADDR_W]
wdata  input  NREQ*DATA_W  packed write data, requester i at [i*DATA_W +: DATA_W]
grant  output  NREQ  one-hot registered grant
ack  output  NREQ  one-cycle pulse, write committed for requester i
busy  output  1  high whenever state != IDLE
rd_addr  input  ADDR_W  read address
rd_data  output  DATA_W  combinational bank[rd_addr]

Behaviour:
- Reset is sampled only on CLK posedge: state=IDLE, grant=0, ack=0, busy=0, every bank entry=0, round-robin pointer last=NREQ-1 (requester 0 wins first).
- Reset has priority over every other event. Asserting reset mid-transaction drops grant/ack next edge, performs no write, and clears the bank.
- FSM states: IDLE, WRITE, RELEASE.
- IDLE:
  - If req!=0, select the first set req bit searching last+1, last+2, ... modulo NREQ.
  - Next edge: grant=onehot(winner), last=winner, state=WRITE.
  - If req==0, stay IDLE.
- WRITE, one cycle. The granted requester must hold req, addr and wdata stable.
  - If req[winner]=1 at the edge: bank[addr_winner]<=wdata_winner, ack[winner]=1 for exactly the next cycle, grant=0, state=RELEASE.
  - If req[winner]=0 (abort): no write, no ack, grant=0, state=IDLE.
  - Requests from other requesters during WRITE are ignored; they stay pending.
- RELEASE, one cycle:
  - ack is high during this cycle; next edge ack=0, state=IDLE.
  - req is not arbitrated in RELEASE.
- Latency: req rises in cycle 0 (state IDLE) -> grant high in cycle 1 -> bank updated and ack high in cycle 2 -> IDLE in cycle 3.
  - Minimum back-to-back write throughput: 1 write per 3 cycles.
- Requester protocol:
  - Deassert req in the ack cycle, or it re-enters arbitration in the following IDLE.
  - Round-robin guarantees it will not win again while others are pending.
- Fairness: with all NREQ requesting continuously, grants rotate 0,1,...,NREQ-1,0 with no repeats.
- rd_data reflects a committed write in the cycle ack is high (same-edge update). rd_data for the address being written in WRITE shows the old value.
- Addresses wrap naturally within ADDR_W bits; no out-of-range case exists.
- grant is always zero or one-hot; ack is always zero or one-hot and equals the previous cycle's grant when committed.

Optional Feature:
ARB_WRITE_COUNT_EN
- Defined: adds output wr_count [15:0].
  - Reset to 0; increments by 1 on every committed write (the edge setting ack); saturates at 16'hFFFF.
  - Aborts and resets do not increment.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset held 2 cycles, then rd_addr swept 0..7 -> rd_data=0 for all; grant=0, ack=0, busy=0.
- Single write: req[2]=1, addr2=5, wdata2=8'hA5 held -> grant=4'b0100 cycle 1, ack=4'b0100 cycle 2 only, bank[5]=8'hA5, busy high cycles 1-2.
- All four req high continuously with distinct addr/data -> grants in order 0,1,2,3,0, each 3 cycles apart; each ack matches its data in the bank.
- Abort: req[1] rises, winner 1 granted, req[1] dropped during WRITE -> no ack, bank unchanged, IDLE next cycle; a subsequent req[0] is granted with pointer last=1 (requester 2 preferred if also pending).
- Reset mid-WRITE after bank[3]=8'h3C was written -> next cycle grant=0, ack=0, bank[3]=0, state IDLE.
- With ARB_WRITE_COUNT_EN: 5 committed writes plus 1 abort -> wr_count=5; after reset wr_count=0.

Source files
------------

// File: rtl/regbank_write_arbiter_if.sv
// regbank_write_arbiter_if
//   Bundles the requester-side write handshake and the combinational read
//   port of the shared register bank.
//   Signals:
//     req     [NREQ]         per-requester write request (level)
//     addr    [NREQ*ADDR_W]  packed write addresses, requester i at [i*ADDR_W +: ADDR_W]
//     wdata   [NREQ*DATA_W]  packed write data, requester i at [i*DATA_W +: DATA_W]
//     grant   [NREQ]         registered one-hot grant
//     ack     [NREQ]         one-cycle commit pulse
//     busy                   arbiter not idle
//     rd_addr [ADDR_W]       read address
//     rd_data [DATA_W]       bank[rd_addr]
//   Modports: master = requester agents, slave = arbiter.
interface regbank_write_arbiter_if #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
);
  logic [NREQ-1:0]        req;
  logic [NREQ*ADDR_W-1:0] addr;
  logic [NREQ*DATA_W-1:0] wdata;
  logic [NREQ-1:0]        grant;
  logic [NREQ-1:0]        ack;
  logic                   busy;
  logic [ADDR_W-1:0]      rd_addr;
  logic [DATA_W-1:0]      rd_data;

  modport master (
    output req, addr, wdata, rd_addr,
    input  grant, ack, busy, rd_data
  );

  modport slave (
    input  req, addr, wdata, rd_addr,
    output grant, ack, busy, rd_data
  );
endinterface

// File: rtl/regbank_write_arbiter.sv
// regbank_write_arbiter
//   Round-robin write arbiter and sequencer in front of a bank of 2**ADDR_W
//   registers of DATA_W bits. One requester is granted at a time; its
//   address/data is committed one cycle after the grant and acknowledged
//   with a single-cycle pulse. Reads are combinational.
//   Ports:
//     CLK    clock, all state updates on posedge
//     reset  synchronous, active-high; clears FSM, grant/ack and the bank
//     bus    regbank_write_arbiter_if.slave (req/addr/wdata/grant/ack/busy/rd_addr/rd_data)
//     wr_count [15:0] (only with ARB_WRITE_COUNT_EN) saturating count of committed writes
//   Optional feature macro: ARB_WRITE_COUNT_EN
module regbank_write_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic CLK,
  input  logic reset,
  regbank_write_arbiter_if.slave bus
`ifdef ARB_WRITE_COUNT_EN
  ,
  output logic [15:0] wr_count
`endif
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    RELEASE
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [IDX_W-1:0]  pick, cand;
  logic              found;
  logic              we;

  logic [DATA_W-1:0] bank_q [DEPTH];

  logic [ADDR_W-1:0] addr_arr [NREQ];
  logic [DATA_W-1:0] data_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_arr[g] = bus.addr[g*ADDR_W +: ADDR_W];
    assign data_arr[g] = bus.wdata[g*DATA_W +: DATA_W];
  end

  // Rotating priority search starting just after the last winner.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    cand  = last_q;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand = IDX_W'((32'(last_q) + off) % NREQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // last_q holds the current winner while in WRITE.
  always_comb begin
    state_d = state_q;
    grant_d = '0;
    ack_d   = '0;
    last_d  = last_q;
    we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d[pick] = 1'b1;
          last_d        = pick;
          state_d       = WRITE;
        end
      end
      WRITE: begin
        if (bus.req[last_q]) begin
          we            = 1'b1;
          ack_d[last_q] = 1'b1;
          state_d       = RELEASE;
        end else begin
          state_d = IDLE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ack_q   <= '0;
      last_q  <= IDX_W'(NREQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      bank_q <= '{default: '0};
    end else if (we) begin
      bank_q[addr_arr[last_q]] <= data_arr[last_q];
    end
  end

`ifdef ARB_WRITE_COUNT_EN
  logic [15:0] wr_count_q;

  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_count_q <= '0;
    end else if (we && (wr_count_q != '1)) begin
      wr_count_q <= wr_count_q + 16'd1;
    end
  end

  assign wr_count = wr_count_q;
`endif

  assign bus.grant   = grant_q;
  assign bus.ack     = ack_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.rd_data = bank_q[bus.rd_addr];

endmodule

// File: tb/tb_regbank_write_arbiter.sv
module tb_regbank_write_arbiter;

  logic CLK;
  logic reset;
  int   checks;
  int   failures;

  regbank_write_arbiter_if #(.NREQ(4), .DATA_W(8), .ADDR_W(3)) bus ();

`ifdef ARB_WRITE_COUNT_EN
  logic [15:0] wr_count;
`endif

  regbank_write_arbiter #(.NREQ(4), .DATA_W(8), .ADDR_W(3)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
`ifdef ARB_WRITE_COUNT_EN
    ,
    .wr_count (wr_count)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Transaction-level reference: which requester owns the bank and how many
  // cycles into its transaction we are (0 = idle, 1 = granted, 2 = acked).
  int          m_phase;
  int          m_last;
  int          m_owner;
  logic [7:0]  m_bank [8];
  int          m_count;

  function automatic logic [2:0] addr_of(input logic [11:0] a, input int i);
    logic [11:0] s;
    s = a >> (3 * i);
    return s[2:0];
  endfunction

  function automatic logic [7:0] data_of(input logic [31:0] d, input int i);
    logic [31:0] s;
    s = d >> (8 * i);
    return s[7:0];
  endfunction

  function automatic logic [3:0] onehot(input int i);
    logic [3:0] v;
    v = '0;
    v[i[1:0]] = 1'b1;
    return v;
  endfunction

  task automatic model_step();
    if (reset) begin
      m_phase = 0;
      m_last  = 3;
      m_owner = -1;
      m_count = 0;
      for (int i = 0; i < 8; i++) m_bank[i] = 8'h00;
    end else if (m_phase == 0) begin
      if (bus.req != 4'b0000) begin
        for (int k = 1; k <= 4; k++) begin
          int c;
          c = (m_last + k) % 4;
          if (m_owner < 0 && bus.req[c[1:0]]) m_owner = c;
        end
        m_last  = m_owner;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (bus.req[m_owner[1:0]]) begin
        m_bank[addr_of(bus.addr, m_owner)] = data_of(bus.wdata, m_owner);
        if (m_count < 65535) m_count++;
        m_phase = 2;
      end else begin
        m_phase = 0;
        m_owner = -1;
      end
    end else begin
      m_phase = 0;
      m_owner = -1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [3:0] eg;
    logic [3:0] ea;
    eg = (m_phase == 1) ? onehot(m_owner) : 4'b0000;
    ea = (m_phase == 2) ? onehot(m_owner) : 4'b0000;
    chk("grant", 32'(bus.grant), 32'(eg));
    chk("ack", 32'(bus.ack), 32'(ea));
    chk("busy", 32'(bus.busy), 32'(m_phase != 0));
    chk("rd_data", 32'(bus.rd_data), 32'(m_bank[bus.rd_addr]));
    chk("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
`ifdef ARB_WRITE_COUNT_EN
    chk("wr_count", 32'(wr_count), 32'(m_count));
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [2:0]  rd_addr;
    logic [3:0]  exp_grant;
    logic [3:0]  exp_ack;
    logic        exp_busy;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vt [6];

  initial begin
    checks      = 0;
    failures    = 0;
    m_owner     = -1;
    reset       = 1'b1;
    bus.req     = '0;
    bus.addr    = '0;
    bus.wdata   = '0;
    bus.rd_addr = '0;

    // Reset for two cycles, then a single write from requester 2 to bank[5].
    vt[0] = '{1'b1, 4'b0000, 12'h000, 32'h0000_0000, 3'd0, 4'b0000, 4'b0000, 1'b0, 8'h00};
    vt[1] = '{1'b1, 4'b0000, 12'h000, 32'h0000_0000, 3'd0, 4'b0000, 4'b0000, 1'b0, 8'h00};
    vt[2] = '{1'b0, 4'b0100, 12'h140, 32'h00A5_0000, 3'd5, 4'b0100, 4'b0000, 1'b1, 8'h00};
    vt[3] = '{1'b0, 4'b0100, 12'h140, 32'h00A5_0000, 3'd5, 4'b0000, 4'b0100, 1'b1, 8'hA5};
    vt[4] = '{1'b0, 4'b0000, 12'h140, 32'h00A5_0000, 3'd5, 4'b0000, 4'b0000, 1'b0, 8'hA5};
    vt[5] = '{1'b0, 4'b0000, 12'h000, 32'h0000_0000, 3'd0, 4'b0000, 4'b0000, 1'b0, 8'h00};

    for (int i = 0; i < 6; i++) begin
      reset       = vt[i].rst;
      bus.req     = vt[i].req;
      bus.addr    = vt[i].addr;
      bus.wdata   = vt[i].wdata;
      bus.rd_addr = vt[i].rd_addr;
      tick();
      chk("tbl_grant", 32'(bus.grant), 32'(vt[i].exp_grant));
      chk("tbl_ack", 32'(bus.ack), 32'(vt[i].exp_ack));
      chk("tbl_busy", 32'(bus.busy), 32'(vt[i].exp_busy));
      chk("tbl_rd", 32'(bus.rd_data), 32'(vt[i].exp_rd));
      if (i == 1) begin
        for (int a = 0; a < 8; a++) begin
          bus.rd_addr = 3'(a);
          #1;
          chk("reset_sweep_rd", 32'(bus.rd_data), 32'h0);
        end
`ifdef ARB_WRITE_COUNT_EN
        chk("reset_wr_count", 32'(wr_count), 32'h0);
`endif
      end
    end

    // All four requesting: grants must rotate 0,1,2,3,0.
    do_reset();
    bus.req   = 4'hF;
    bus.addr  = {3'd4, 3'd3, 3'd2, 3'd1};
    bus.wdata = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int g = 0; g < 5; g++) begin
      int r;
      r = g % 4;
      bus.rd_addr = 3'(r + 1);
      tick();
      chk("rr_grant", 32'(bus.grant), 32'(onehot(r)));
      check_model();
      tick();
      chk("rr_ack", 32'(bus.ack), 32'(onehot(r)));
      chk("rr_bank", 32'(bus.rd_data), 32'(8'h10 + 8'(r)));
      tick();
      chk("rr_idle_busy", 32'(bus.busy), 32'd0);
      check_model();
    end
    bus.req = 4'h0;
    tick();
    check_model();

    // Abort: requester 1 drops req during WRITE.
    bus.req     = 4'b0010;
    bus.addr    = 12'(6) << 3;
    bus.wdata   = 32'h0000_6600;
    bus.rd_addr = 3'd6;
    tick();
    chk("abort_grant", 32'(bus.grant), 32'h2);
    bus.req = 4'b0000;
    tick();
    chk("abort_ack", 32'(bus.ack), 32'h0);
    chk("abort_busy", 32'(bus.busy), 32'h0);
    chk("abort_bank", 32'(bus.rd_data), 32'h0);
`ifdef ARB_WRITE_COUNT_EN
    chk("abort_wr_count", 32'(wr_count), 32'd5);
`endif
    bus.req   = 4'b0101;
    bus.addr  = {3'd0, 3'd7, 3'd0, 3'd2};
    bus.wdata = 32'h0077_0022;
    tick();
    chk("after_abort_pref2", 32'(bus.grant), 32'h4);
    bus.req = 4'b0001;
    tick();
    check_model();
    tick();
    chk("after_abort_req0", 32'(bus.grant), 32'h1);
    tick();
    check_model();
    bus.req = 4'b0000;
    tick();
    check_model();

    // Reset during WRITE after bank[3] holds 8'h3C.
    do_reset();
    bus.req     = 4'b0001;
    bus.addr    = 12'd3;
    bus.wdata   = 32'h0000_003C;
    bus.rd_addr = 3'd3;
    tick();
    tick();
    chk("pre_reset_bank3", 32'(bus.rd_data), 32'h3C);
    bus.req = 4'b0000;
    tick();
    bus.req   = 4'b0001;
    bus.wdata = 32'h0000_0077;
    tick();
    chk("mid_grant", 32'(bus.grant), 32'h1);
    reset = 1'b1;
    tick();
    chk("mid_reset_grant", 32'(bus.grant), 32'h0);
    chk("mid_reset_ack", 32'(bus.ack), 32'h0);
    chk("mid_reset_busy", 32'(bus.busy), 32'h0);
    chk("mid_reset_bank3", 32'(bus.rd_data), 32'h0);
    check_model();
    reset   = 1'b0;
    bus.req = 4'b0000;
    tick();
    check_model();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      reset       = ($urandom_range(0, 59) == 0);
      bus.req     = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      bus.addr    = 12'($urandom);
      bus.wdata   = $urandom;
      bus.rd_addr = 3'($urandom_range(0, 7));
      tick();
      check_model();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
